mac_accumulator: RTL

MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

---
 rtl/mac_accumulator.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mac_accumulator.sv
// Block accumulator for products from a sequential multiplier; emits one sum per block.
// Optional sticky overwrite flag acc_overrun_o is built when MAC_ACC_OVERRUN_EN is defined.
module mac_accumulator (
  input  logic        acc_clk_i,
  input  logic        acc_reset_i,
  input  logic [9:0]  product_i,
  input  logic        product_valid_i,
  input  logic [3:0]  length_i,
  input  logic        acc_ready_i,
  output logic [13:0] acc_result_o,
  output logic        acc_valid_o,
  output logic [3:0]  acc_count_o,
  output logic        acc_busy_o
`ifdef MAC_ACC_OVERRUN_EN
  ,
  output logic        acc_overrun_o
`endif
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_stateNext;

  logic        r_prevValid;
  logic [3:0]  r_lenQ;
  logic [3:0]  r_count;
  logic [13:0] r_sumQ;
  logic [13:0] r_result;
  logic        r_valid;

  logic        w_capture;
  logic [3:0]  w_lenSel;
  logic [4:0]  w_target;
  logic        w_complete;
  logic [13:0] w_sumAdd;
  logic [3:0]  w_lenNext;
  logic [3:0]  w_countNext;
  logic [13:0] w_sumQNext;
  logic [13:0] w_resultNext;
  logic        w_validNext;

  // A held-high valid level yields a single capture on its rising transition.
  assign w_capture = product_valid_i & ~r_prevValid;

  always_comb begin
    w_stateNext  = r_state;
    w_lenNext    = r_lenQ;
    w_countNext  = r_count;
    w_sumQNext   = r_sumQ;
    w_lenSel     = r_lenQ;
    w_sumAdd     = r_sumQ + {4'b0000, product_i};
    w_complete   = 1'b0;
    w_resultNext = r_result;
    w_validNext  = r_valid;

    case (r_state)
      ST_IDLE: begin
        if (w_capture) begin
          w_lenSel  = length_i;
          w_lenNext = length_i;
          w_sumAdd  = {4'b0000, product_i};
        end
      end
      ST_ACCUM: begin
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase

    w_target = (w_lenSel == 4'd0) ? 5'd16 : {1'b0, w_lenSel};

    if (w_capture) begin
      if (({1'b0, r_count} + 5'd1) == w_target) begin
        w_complete  = 1'b1;
        w_sumQNext  = 14'd0;
        w_countNext = 4'd0;
        w_stateNext = ST_IDLE;
      end else begin
        w_sumQNext  = w_sumAdd;
        w_countNext = r_count + 4'd1;
        w_stateNext = ST_ACCUM;
      end
    end

    // A completion wins over an ack: the new sum is loaded and stays valid.
    if (w_complete) begin
      w_resultNext = w_sumAdd;
      w_validNext  = 1'b1;
    end else if (r_valid && acc_ready_i) begin
      w_validNext  = 1'b0;
    end
  end

  always_ff @(posedge acc_clk_i) begin
    if (acc_reset_i) begin
      r_state     <= ST_IDLE;
      r_prevValid <= 1'b1;
      r_lenQ      <= 4'd0;
      r_count     <= 4'd0;
      r_sumQ      <= 14'd0;
      r_result    <= 14'd0;
      r_valid     <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_prevValid <= product_valid_i;
      r_lenQ      <= w_lenNext;
      r_count     <= w_countNext;
      r_sumQ      <= w_sumQNext;
      r_result    <= w_resultNext;
      r_valid     <= w_validNext;
    end
  end

`ifdef MAC_ACC_OVERRUN_EN
  logic r_overrun;
  logic w_overrunSet;

  assign w_overrunSet = w_complete & r_valid & ~acc_ready_i;

  always_ff @(posedge acc_clk_i) begin
    if (acc_reset_i) begin
      r_overrun <= 1'b0;
    end else if (w_overrunSet) begin
      r_overrun <= 1'b1;
    end
  end

  assign acc_overrun_o = r_overrun;
`endif

  assign acc_result_o = r_result;
  assign acc_valid_o  = r_valid;
  assign acc_count_o  = r_count;
  assign acc_busy_o   = (r_count != 4'd0);

endmodule
